cmd_scheduler: RTL
==================

Name: cmd_scheduler

Overview:
- Sequences all traffic into the on-chip command serializer's 16-bit command FIFO (wr_cmd/datain/fifo_full, clk40 side).
- Arbitrates three sources by fixed priority: triggers, fast commands (ECR/BCR/global pulse), and multi-word register-access packets.
- Keeps register packets atomic.
- Forces an explicit sync word into the stream at least every SYNC_INTERVAL words, so the receiver keeps frame lock even under continuous traffic.

Parameters:
SYNC_INTERVAL, 32, maximum command words written between forced sync words (legal range 2..255)
SYNC_WORD, 16'h817E, word written as the forced sync frame

Ports:
clk40  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
trig_req  in  1  trigger request, level; held until trig_ack
trig_word  in  16  trigger command word, stable while trig_req high
trig_ack  out  1  one-cycle pulse: trig_word accepted this cycle
fast_req  in  1  fast-command request, level; held until fast_ack
fast_word  in  16  fast command word
fast_ack  out  1  one-cycle pulse: fast_word accepted this cycle
pkt_valid  in  1  register-packet word valid
pkt_data  in  16  register-packet word
pkt_last  in  1  marks final word of packet
pkt_ready  out  1  combinational; pkt word accepted when pkt_valid & pkt_ready
fifo_full  in  1  command FIFO full
wr_cmd  out  1  registered FIFO write enable
cmd_word  out  16  registered FIFO write data
busy  out  1  high while a packet is in progress (state PKT)
sync_count  out  16  number of forced sync words written; wraps at 65535

Behaviour:
- Reset values: wr_cmd=0, cmd_word=16'h0000, trig_ack=0, fast_ack=0, pkt_ready=0, busy=0, sync_count=0; state=IDLE; word counter wcnt=0.
- Reset asserted mid-packet abandons the partial packet. Upstream must re-send the packet from its first word.
- One word is accepted per cycle at most. A grant is made only when fifo_full=0; no grant means no acks/ready that cycle.
- The accepted word appears on cmd_word with wr_cmd=1 on the following cycle (latency 1). wr_cmd=0 in every other cycle.
- Integration constraint: the FIFO full flag asserts at depth-1, so the one in-flight registered word can never overflow.
- wcnt counts words written since the last sync, including trigger, fast and packet words. It saturates at SYNC_INTERVAL. sync_due = (wcnt == SYNC_INTERVAL).
- State IDLE, priority when fifo_full=0:
  1. sync_due: write SYNC_WORD, wcnt<=0, sync_count++.
  2. trig_req: write trig_word, trig_ack=1.
  3. fast_req: write fast_word, fast_ack=1.
  4. pkt_valid: pkt_ready=1, write pkt_data. If pkt_last=0, go to PKT.
- In IDLE, pkt_ready=1 only when case 4 is selected.
- State PKT:
  - pkt_ready = !fifo_full; triggers, fast commands and sync are all held off.
  - Accepted word is written. If pkt_last=1, return to IDLE.
  - pkt_valid=0 writes nothing (no padding); the source must keep gaps short.
- A single-word packet (pkt_last on the first word) never enters PKT.
- Simultaneous trig_req, fast_req and pkt_valid: served over consecutive cycles in the order trig, fast, pkt.
- A request that drops without an ack is lost; this is an upstream protocol violation and is not detected.
- Sync due during a packet is deferred to the first IDLE cycle after pkt_last. It then precedes any pending trigger.
- Any word written counts toward wcnt, except SYNC_WORD, which clears it.

Test Plan:
- Reset with all requests low: wr_cmd stays 0 for 100 cycles, sync_count=0, busy=0.
- trig_req=1 with trig_word=16'h2B2B, fast_req=1 with fast_word=16'h5A5A, same cycle: trig_ack in cycle N, fast_ack in N+1; cmd_word=2B2B at N+1, 5A5A at N+2.
- 4-word packet 1111/2222/3333/4444 with trig_req raised on word 2: words written contiguously, busy high words 1-3. Trigger written the cycle after 4444.
- Continuous fast_req, SYNC_INTERVAL=32: after 32 fast words, one 16'h817E is written, sync_count=1; pattern repeats every 33 writes.
- fifo_full=1 for 5 cycles during a packet: no wr_cmd and pkt_ready=0 in those cycles; packet resumes with no lost or duplicated words.
- rst pulsed after word 2 of a 4-word packet: outputs return to reset values, state IDLE. A fresh 2-word packet is then written correctly.

Source files
------------

// File: rtl/cmd_scheduler.sv
// Command scheduler: arbitrates triggers, fast commands and atomic register packets
// into the serializer's 16-bit command FIFO, inserting a sync word at bounded intervals.
module cmd_scheduler #(
  parameter int unsigned SYNC_INTERVAL = 32,
  parameter logic [15:0] SYNC_WORD     = 16'h817E
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic        trig_req,
  input  logic [15:0] trig_word,
  output logic        trig_ack,
  input  logic        fast_req,
  input  logic [15:0] fast_word,
  output logic        fast_ack,
  input  logic        pkt_valid,
  input  logic [15:0] pkt_data,
  input  logic        pkt_last,
  output logic        pkt_ready,
  input  logic        fifo_full,
  output logic        wr_cmd,
  output logic [15:0] cmd_word,
  output logic        busy,
  output logic [15:0] sync_count
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] SYNC_LIMIT = CNT_W'(SYNC_INTERVAL);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wcnt;
  logic               sync_due;
  logic               wr_nxt;
  logic               sync_sel;
  logic [WORD_W-1:0]  word_nxt;

  assign sync_due = (wcnt == SYNC_LIMIT);
  assign busy     = (state == PKT);

  // State register
  always_ff @(posedge clk40) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant selection; acks and pkt_ready are same-cycle handshakes with the sources
  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    sync_sel  = 1'b0;
    word_nxt  = cmd_word;
    trig_ack  = 1'b0;
    fast_ack  = 1'b0;
    pkt_ready = 1'b0;
    if (!rst && !fifo_full) begin
      unique case (state)
        IDLE: begin
          if (sync_due) begin
            wr_nxt   = 1'b1;
            sync_sel = 1'b1;
            word_nxt = SYNC_WORD;
          end else if (trig_req) begin
            wr_nxt   = 1'b1;
            trig_ack = 1'b1;
            word_nxt = trig_word;
          end else if (fast_req) begin
            wr_nxt   = 1'b1;
            fast_ack = 1'b1;
            word_nxt = fast_word;
          end else if (pkt_valid) begin
            wr_nxt    = 1'b1;
            pkt_ready = 1'b1;
            word_nxt  = pkt_data;
            if (!pkt_last) state_nxt = PKT;
          end
        end
        PKT: begin
          // Packet owns the FIFO until its last word; sync is deferred
          pkt_ready = 1'b1;
          if (pkt_valid) begin
            wr_nxt   = 1'b1;
            word_nxt = pkt_data;
            if (pkt_last) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output register, words-since-sync counter and sync statistics
  always_ff @(posedge clk40) begin
    if (rst) begin
      wr_cmd     <= 1'b0;
      cmd_word   <= '0;
      wcnt       <= '0;
      sync_count <= '0;
    end else begin
      wr_cmd <= wr_nxt;
      if (wr_nxt) cmd_word <= word_nxt;
      if (sync_sel) begin
        wcnt       <= '0;
        sync_count <= sync_count + 16'd1;
      end else if (wr_nxt && !sync_due) begin
        wcnt <= wcnt + CNT_W'(1);
      end
    end
  end

endmodule
